mem_stage: RTL and testbench

Memory-access stage that consumes the EX/MEM pipeline register outputs (branch target, zero flag, ALU result, store data, destination register) and produces the MEM/WB register contents. It resolves branches, performs word loads and stores into a local data memory with a configurable number of wait states, and stalls the upstream stages while an access is in progress. It sits between the EX/MEM buffer and the write-back stage of the pipelined datapath.

---
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Resolves branches, performs word loads/stores into a local data memory
// that takes WAIT_STATES extra cycles per access, stalls upstream stages
// while an access is in progress and produces the MEM/WB register contents.
module mem_stage #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_adder,
    input  logic        in_zf,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_rd2,
    input  logic [4:0]  in_mux5b,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_branch,
    input  logic        in_reg_write,
    input  logic        in_mem_to_reg,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        out_valid,
    output logic [31:0] out_read_data,
    output logic [31:0] out_alu,
    output logic [4:0]  out_mux5b,
    output logic        out_reg_write,
    output logic        out_mem_to_reg
);

    // Counter must hold values 0..WAIT_STATES; at least one bit wide.
    localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [CW-1:0] WS_CNT = CW'(WAIT_STATES);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    logic [31:0]          mem [0:DEPTH-1];
    logic [ADDR_BITS-1:0] idx;
    logic                 memop;
    logic                 accept;
    logic                 mem_we;
    state_e               state;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 out_valid_q;
    logic [31:0]          out_read_data_q;
    logic [31:0]          out_alu_q;
    logic [4:0]           out_mux5b_q;
    logic                 out_reg_write_q;
    logic                 out_mem_to_reg_q;

    // Byte address to word index; low two bits and bits above the memory
    // size are dropped so addresses alias modulo the memory size.
    assign idx    = in_alu[ADDR_BITS+1:2];
    assign memop  = in_valid & (in_mem_read | in_mem_write);
    assign stall  = memop & (cnt_q != WS_CNT);
    assign accept = in_valid & ~stall;
    // Writes only happen on the completion edge, so a reset in mid-access
    // can never leave a half-finished store behind.
    assign mem_we = accept & in_mem_write & rst_n;

    assign pc_src        = in_valid & in_branch & in_zf;
    assign branch_target = in_adder;

    // Wait-state counter register; it is the FSM state (0 = IDLE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Next count: advance while stalling, otherwise return to IDLE.
    always_comb begin
        state = (cnt_q == '0) ? IDLE : BUSY;
        cnt_d = '0;
        case (state)
            IDLE:    if (stall) cnt_d = CW'(1);
            BUSY:    if (stall) cnt_d = cnt_q + CW'(1);
            default: cnt_d = '0;
        endcase
    end

    // Data memory write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= in_rd2;
        end
    end

    // MEM/WB register: load on completion, insert a bubble otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            out_read_data_q  <= '0;
            out_alu_q        <= '0;
            out_mux5b_q      <= '0;
            out_reg_write_q  <= 1'b0;
            out_mem_to_reg_q <= 1'b0;
        end else if (accept) begin
            out_valid_q      <= 1'b1;
            out_alu_q        <= in_alu;
            out_mux5b_q      <= in_mux5b;
            out_reg_write_q  <= in_reg_write;
            out_mem_to_reg_q <= in_mem_to_reg;
            if (in_mem_read) begin
                out_read_data_q <= mem[idx];
            end
        end else begin
            out_valid_q      <= 1'b0;
            out_reg_write_q  <= 1'b0;
            out_mem_to_reg_q <= 1'b0;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_read_data  = out_read_data_q;
    assign out_alu        = out_alu_q;
    assign out_mux5b      = out_mux5b_q;
    assign out_reg_write  = out_reg_write_q;
    assign out_mem_to_reg = out_mem_to_reg_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed plus randomized checks of mem_stage against a
// transaction-level model (word array plus expected MEM/WB contents).
module tb_mem_stage;

    localparam int ADDR_BITS   = 8;
    localparam int WAIT_STATES = 2;
    localparam int DEPTH       = 1 << ADDR_BITS;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_adder;
    logic        in_zf;
    logic [31:0] in_alu;
    logic [31:0] in_rd2;
    logic [4:0]  in_mux5b;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_branch;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        out_valid;
    logic [31:0] out_read_data;
    logic [31:0] out_alu;
    logic [4:0]  out_mux5b;
    logic        out_reg_write;
    logic        out_mem_to_reg;

    int vectors;
    int miscompares;

    // Reference model state
    logic [31:0] modelMem [0:DEPTH-1];
    bit          written  [0:DEPTH-1];
    logic        expValid;
    logic [31:0] expRd;
    logic [31:0] expAlu;
    logic [4:0]  expMux;
    logic        expRw;
    logic        expM2r;

    mem_stage #(
        .ADDR_BITS  (ADDR_BITS),
        .WAIT_STATES(WAIT_STATES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_adder      (in_adder),
        .in_zf         (in_zf),
        .in_alu        (in_alu),
        .in_rd2        (in_rd2),
        .in_mux5b      (in_mux5b),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_branch     (in_branch),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .out_valid     (out_valid),
        .out_read_data (out_read_data),
        .out_alu       (out_alu),
        .out_mux5b     (out_mux5b),
        .out_reg_write (out_reg_write),
        .out_mem_to_reg(out_mem_to_reg)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkMemWb(input string tag);
        checkBit({tag, "_valid"}, out_valid, expValid);
        checkOutput({tag, "_rdata"}, out_read_data, expRd);
        checkOutput({tag, "_alu"}, out_alu, expAlu);
        checkOutput({tag, "_mux5b"}, {27'd0, out_mux5b}, {27'd0, expMux});
        checkBit({tag, "_regwr"}, out_reg_write, expRw);
        checkBit({tag, "_m2r"}, out_mem_to_reg, expM2r);
    endtask

    task automatic clearModelRegs();
        expValid = 1'b0;
        expRd    = '0;
        expAlu   = '0;
        expMux   = '0;
        expRw    = 1'b0;
        expM2r   = 1'b0;
    endtask

    // Present one EX/MEM entry (entered just after a rising edge), check the
    // combinational outputs, the stall window and the MEM/WB result.
    task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [31:0] rd2,
                                 input logic [4:0] rdst, input logic mr, input logic mw,
                                 input logic br, input logic zf, input logic [31:0] adder,
                                 input logic rw, input logic m2r);
        int nStall;
        int idx;
        in_valid      = v;
        in_alu        = alu;
        in_rd2        = rd2;
        in_mux5b      = rdst;
        in_mem_read   = mr;
        in_mem_write  = mw;
        in_branch     = br;
        in_zf         = zf;
        in_adder      = adder;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
        #1;
        checkBit("pc_src", pc_src, v & br & zf);
        checkOutput("branch_target", branch_target, adder);
        nStall = (v && (mr || mw)) ? WAIT_STATES : 0;
        for (int k = 0; k < nStall; k++) begin
            checkBit("stall_hi", stall, 1'b1);
            @(posedge clk);
            #1;
            checkBit("bubble_valid", out_valid, 1'b0);
            checkBit("bubble_regwr", out_reg_write, 1'b0);
            checkOutput("bubble_alu_hold", out_alu, expAlu);
        end
        checkBit("stall_lo", stall, 1'b0);
        idx = int'(alu[ADDR_BITS+1:2]);
        if (v) begin
            expValid = 1'b1;
            expAlu   = alu;
            expMux   = rdst;
            expRw    = rw;
            expM2r   = m2r;
            if (mr) expRd = modelMem[idx];
            if (mw) begin
                modelMem[idx] = rd2;
                written[idx]  = 1'b1;
            end
        end else begin
            expValid = 1'b0;
            expRw    = 1'b0;
            expM2r   = 1'b0;
        end
        @(posedge clk);
        #1;
        checkMemWb("memwb");
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] r2;
        logic [7:0]  ridx;
        logic        v, mr, mw;
        int          kind;

        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < DEPTH; i++) begin
            modelMem[i] = '0;
            written[i]  = 1'b0;
        end
        clearModelRegs();

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_adder      = '0;
        in_zf         = 1'b0;
        in_alu        = '0;
        in_rd2        = '0;
        in_mux5b      = '0;
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        in_branch     = 1'b0;
        in_reg_write  = 1'b0;
        in_mem_to_reg = 1'b0;

        // Reset held with non-memory inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            r             = $urandom();
            in_valid      = r[0];
            in_alu        = $urandom();
            in_mux5b      = r[8:4];
            in_reg_write  = r[1];
            in_mem_to_reg = r[2];
            in_branch     = r[3];
            @(posedge clk);
            #1;
            checkMemWb("reset");
            checkBit("reset_stall", stall, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        checkBit("post_reset_valid", out_valid, 1'b0);

        // Store then load at 0x10
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("load_deadbeef", out_read_data, 32'hDEADBEEF);

        // ALU op
        applyStimulus(1'b1, 32'h1234, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Branch taken and not taken
        applyStimulus(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0);

        // Address wrap and aliasing
        applyStimulus(1'b1, 32'h403, 32'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h000, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("alias_load", out_read_data, 32'h55);

        // Read and write together returns the old word
        applyStimulus(1'b1, 32'h10, 32'hCAFEF00D, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("rbw_old", out_read_data, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h10, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("rbw_new", out_read_data, 32'hCAFEF00D);

        // Invalid entry produces a bubble
        applyStimulus(1'b0, 32'h99, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 1'b1, 1'b1);

        // Abort: reset in the second stall cycle of a store to 0x20
        applyStimulus(1'b1, 32'h20, 32'h1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        in_valid     = 1'b1;
        in_alu       = 32'h20;
        in_rd2       = 32'hBAD;
        in_mem_read  = 1'b0;
        in_mem_write = 1'b1;
        #1;
        checkBit("abort_stall0", stall, 1'b1);
        @(posedge clk);
        #1;
        checkBit("abort_stall1", stall, 1'b1);
        rst_n = 1'b0;
        #1;
        clearModelRegs();
        checkMemWb("abort_reset");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h20, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("abort_load", out_read_data, 32'h1);

        // Randomized traffic over a small aliased address pool
        for (int n = 0; n < 150; n++) begin
            r    = $urandom();
            r2   = $urandom();
            ridx = 8'($urandom_range(0, 15));
            kind = $urandom_range(0, 3);
            v    = ($urandom_range(0, 9) != 0);
            mr   = (kind == 1) || (kind == 3);
            mw   = (kind == 2) || (kind == 3);
            if (mr && !written[ridx]) begin
                mr = 1'b0;
                mw = 1'b1;
            end
            applyStimulus(v, {r[31:10], ridx, r[1:0]}, $urandom(), r2[4:0], mr, mw,
                          r2[5], r2[6], $urandom(), r2[7], r2[8]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
